// File: rtl/task_pkg.sv
// rtl/task_pkg.sv - shared constants and framer state encoding for the task answer path
//
// Purpose: holds the task-7 frame marker, the payload length field width and
// the answer framer state encoding so every user agrees on one definition.
// Ports: none (package).

package task_pkg;

  // Width of the payload length field carried with every task packet.
  localparam int TASK_7_PKT_SIZE_IN_BYTES = 12;

  // Marker byte that opens every answer frame.
  localparam logic [7:0] TASK_7_SYNC_BYTE = 8'hA5;

  // Raw state codes, kept as plain constants for older code that compares
  // against bit patterns directly.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_LEN_HI  = 3'd2;
  localparam logic [2:0] ST_LEN_LO  = 3'd3;
  localparam logic [2:0] ST_FETCH   = 3'd4;
  localparam logic [2:0] ST_SETTLE  = 3'd5;
  localparam logic [2:0] ST_PAYLOAD = 3'd6;
  localparam logic [2:0] ST_CSUM    = 3'd7;

  typedef enum logic [2:0] {
    FR_IDLE    = ST_IDLE,
    FR_SYNC    = ST_SYNC,
    FR_LEN_HI  = ST_LEN_HI,
    FR_LEN_LO  = ST_LEN_LO,
    FR_FETCH   = ST_FETCH,
    FR_SETTLE  = ST_SETTLE,
    FR_PAYLOAD = ST_PAYLOAD,
    FR_CSUM    = ST_CSUM
  } task_7_state_e;

endpackage

// File: rtl/task_7_answer_framer.sv
// rtl/task_7_answer_framer.sv - wraps task output packets into sync/length/payload/checksum frames
//
// Purpose: pops payload bytes from the task output FIFO one at a time and emits
// a byte stream: SYNC_BYTE, {4'h0,len[11:8]}, len[7:0], payload, checksum.
// The checksum is the mod-256 sum of both length bytes and all payload bytes.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_tanswer_ready            task output has a byte/packet available
//   i_tdata                    current payload byte at the FIFO head
//   i_tanswer_data_last        FIFO marks the final payload byte (checked only)
//   i_packet_size_in_bytes     payload length, latched at frame start
//   o_tmanager_ready           one-cycle pop strobe to the FIFO
//   o_tx_data/valid/last       framed byte stream, last marks the checksum
//   i_tx_ready                 sink handshake
//   o_busy                     high from frame start until checksum accepted
//   o_err_len                  one-cycle pulse on a last-flag/length mismatch

module task_7_answer_framer
  import task_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = TASK_7_SYNC_BYTE
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_tanswer_ready,
  input  logic [7:0]                          i_tdata,
  input  logic                                i_tanswer_data_last,
  input  logic [TASK_7_PKT_SIZE_IN_BYTES-1:0] i_packet_size_in_bytes,
  output logic                                o_tmanager_ready,
  output logic [7:0]                          o_tx_data,
  output logic                                o_tx_valid,
  input  logic                                i_tx_ready,
  output logic                                o_tx_last,
  output logic                                o_busy,
  output logic                                o_err_len
);

  localparam int LW = TASK_7_PKT_SIZE_IN_BYTES;

  task_7_state_e state;
  logic [LW-1:0] len;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_inc;
  logic [7:0]    csum;
  logic [7:0]    hold;
  logic          tx_fire;

  assign tx_fire = o_tx_valid && i_tx_ready;
  assign cnt_inc = cnt + {{(LW-1){1'b0}}, 1'b1};

  // The pop strobe is only ever raised in FETCH, and FETCH always leaves on
  // the pop edge, so the strobe can never be high two cycles in a row.
  assign o_tmanager_ready = (state == FR_FETCH) && i_tanswer_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= FR_IDLE;
      len        <= '0;
      cnt        <= '0;
      csum       <= '0;
      hold       <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_tx_last  <= 1'b0;
      o_busy     <= 1'b0;
      o_err_len  <= 1'b0;
    end else begin
      o_err_len <= 1'b0;
      case (state)
        FR_IDLE: begin
          if (i_tanswer_ready && (i_packet_size_in_bytes != '0)) begin
            len        <= i_packet_size_in_bytes;
            cnt        <= '0;
            csum       <= '0;
            o_tx_data  <= SYNC_BYTE;
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= FR_SYNC;
          end
        end
        FR_SYNC: begin
          if (tx_fire) begin
            o_tx_data <= {4'h0, len[11:8]};
            state     <= FR_LEN_HI;
          end
        end
        // The checksum accumulates each byte as it is accepted, so the byte
        // currently on o_tx_data is folded in at its accept edge.
        FR_LEN_HI: begin
          if (tx_fire) begin
            csum      <= csum + o_tx_data;
            o_tx_data <= len[7:0];
            state     <= FR_LEN_LO;
          end
        end
        FR_LEN_LO: begin
          if (tx_fire) begin
            csum       <= csum + o_tx_data;
            o_tx_valid <= 1'b0;
            state      <= FR_FETCH;
          end
        end
        FR_FETCH: begin
          if (i_tanswer_ready) begin
            hold      <= i_tdata;
            // The last flag must coincide exactly with byte number len.
            o_err_len <= i_tanswer_data_last != (cnt_inc == len);
            state     <= FR_SETTLE;
          end
        end
        // One idle cycle after the pop lets the FIFO head advance before the
        // next FETCH looks at it again.
        FR_SETTLE: begin
          o_tx_data  <= hold;
          o_tx_valid <= 1'b1;
          state      <= FR_PAYLOAD;
        end
        FR_PAYLOAD: begin
          if (tx_fire) begin
            cnt  <= cnt_inc;
            csum <= csum + o_tx_data;
            if (cnt_inc == len) begin
              o_tx_data <= csum + o_tx_data;
              o_tx_last <= 1'b1;
              state     <= FR_CSUM;
            end else begin
              o_tx_valid <= 1'b0;
              state      <= FR_FETCH;
            end
          end
        end
        FR_CSUM: begin
          if (tx_fire) begin
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            o_busy     <= 1'b0;
            state      <= FR_IDLE;
          end
        end
        default: state <= FR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_7_answer_framer.sv
// tb/tb_task_7_answer_framer.sv - self-checking bench for task_7_answer_framer

module tb_task_7_answer_framer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_tanswer_ready;
  logic [7:0]  i_tdata;
  logic        i_tanswer_data_last;
  logic [11:0] i_packet_size_in_bytes;
  logic        o_tmanager_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_tx_last;
  logic        o_busy;
  logic        o_err_len;

  int n_cmp = 0;
  int n_bad = 0;
  string cur_tag;

  logic [7:0] pay [0:4095];

  typedef struct {
    int size;   // payload length
    int mode;   // 0: sink always ready, 1: sink ready toggles each cycle
    int pat;    // 0: byte i = i+1, 1: byte i = i mod 256
    int early;  // index of an extra, premature last flag (-1 none)
    int csum;   // hand-computed checksum
    int errs;   // expected o_err_len pulses
  } vec_t;

  vec_t vecs [0:6];

  task_7_answer_framer dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_tanswer_ready        (i_tanswer_ready),
    .i_tdata                (i_tdata),
    .i_tanswer_data_last    (i_tanswer_data_last),
    .i_packet_size_in_bytes (i_packet_size_in_bytes),
    .o_tmanager_ready       (o_tmanager_ready),
    .o_tx_data              (o_tx_data),
    .o_tx_valid             (o_tx_valid),
    .i_tx_ready             (i_tx_ready),
    .o_tx_last              (o_tx_last),
    .o_busy                 (o_busy),
    .o_err_len              (o_err_len)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
    end
  endtask

  // Drives one packet through the framer, acting as both FIFO and sink.
  // With abort_at >= 0 the frame is cut by reset once abort_at bytes have been
  // accepted and the next byte is on the bus.
  task automatic run_frame(input int size, input int mode, input int pat,
                           input int early, input int exp_csum,
                           input int exp_err, input int abort_at);
    int idx, nacc, pops, errs, cyc, consec;
    logic prev_stall, prev_pop, done, pop;
    logic [7:0] prev_data, exp_b;
    logic prev_last;
    logic [11:0] sz;
    sz = 12'(size);
    for (int i = 0; i < size; i++) pay[i] = (pat != 0) ? 8'(i) : 8'(i + 1);
    idx = 0; nacc = 0; pops = 0; errs = 0; cyc = 0; consec = 0;
    prev_stall = 1'b0; prev_pop = 1'b0; done = 1'b0;
    prev_data = '0; prev_last = 1'b0;

    @(negedge i_clk);
    i_packet_size_in_bytes = sz;
    i_tanswer_ready = 1'b1;
    i_tdata = pay[0];
    i_tanswer_data_last = (size == 1) || (early == 0);
    i_tx_ready = 1'b1;
    @(posedge i_clk);

    while (!done && cyc < 20000) begin
      @(negedge i_clk);
      cyc++;
      i_tx_ready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
      i_tanswer_ready = (idx < size);
      i_tdata = (idx < size) ? pay[idx] : 8'h00;
      i_tanswer_data_last = (idx == size - 1) || (idx == early);
      #1;
      if (abort_at >= 0 && nacc == abort_at && o_tx_valid) begin
        chk("abort_byte", o_tx_data, 8'h02);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        chk("abort_valid", o_tx_valid, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_pop", o_tmanager_ready, 0);
        i_rst = 1'b0;
        i_tanswer_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(posedge i_clk);
          @(negedge i_clk);
          #1;
          chk("post_abort_valid", o_tx_valid, 0);
        end
        return;
      end
      if (prev_stall) begin
        chk("stall_valid", o_tx_valid, 1);
        chk("stall_data", o_tx_data, prev_data);
        chk("stall_last", o_tx_last, prev_last);
      end
      pop = o_tmanager_ready;
      if (pop) begin
        if (prev_pop) consec++;
        pops++;
      end
      if (o_err_len) errs++;
      if (o_tx_valid && i_tx_ready) begin
        if (nacc == 0) exp_b = 8'hA5;
        else if (nacc == 1) exp_b = {4'h0, sz[11:8]};
        else if (nacc == 2) exp_b = sz[7:0];
        else if (nacc < size + 3) exp_b = pay[nacc - 3];
        else exp_b = 8'(exp_csum);
        chk($sformatf("byte%0d", nacc), o_tx_data, exp_b);
        chk($sformatf("last%0d", nacc), o_tx_last, (nacc == size + 3) ? 1 : 0);
        if (o_tx_last) done = 1'b1;
        nacc++;
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data = o_tx_data;
      prev_last = o_tx_last;
      prev_pop = pop;
      @(posedge i_clk);
      if (pop) idx++;
    end

    chk("frame_done", done, 1);
    chk("frame_len", nacc, size + 4);
    chk("pops", pops, size);
    chk("pop_consec", consec, 0);
    chk("err_pulses", errs, exp_err);
    if (mode == 0) chk("cycles", cyc, 3 * size + 4);
    @(negedge i_clk);
    i_tanswer_ready = 1'b0;
    #1;
    chk("busy_after", o_busy, 0);
    chk("valid_after", o_tx_valid, 0);
  endtask

  initial begin
    vecs[0] = '{size: 4,    mode: 0, pat: 0, early: -1, csum: 'h0E, errs: 0};
    vecs[1] = '{size: 4,    mode: 1, pat: 0, early: -1, csum: 'h0E, errs: 0};
    vecs[2] = '{size: 4,    mode: 0, pat: 0, early: 1,  csum: 'h0E, errs: 1};
    vecs[3] = '{size: 1,    mode: 0, pat: 0, early: -1, csum: 'h02, errs: 0};
    vecs[4] = '{size: 3,    mode: 1, pat: 0, early: -1, csum: 'h09, errs: 0};
    vecs[5] = '{size: 291,  mode: 0, pat: 1, early: -1, csum: 'hF7, errs: 0};
    vecs[6] = '{size: 4095, mode: 0, pat: 1, early: -1, csum: 'h0F, errs: 0};

    i_rst = 1'b1;
    i_tanswer_ready = 1'b0;
    i_tdata = '0;
    i_tanswer_data_last = 1'b0;
    i_packet_size_in_bytes = '0;
    i_tx_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    cur_tag = "reset";
    chk("tx_valid", o_tx_valid, 0);
    chk("tx_last", o_tx_last, 0);
    chk("tx_data", o_tx_data, 0);
    chk("tmanager_ready", o_tmanager_ready, 0);
    chk("busy", o_busy, 0);
    chk("err_len", o_err_len, 0);
    i_rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      cur_tag = $sformatf("vec%0d", v);
      run_frame(vecs[v].size, vecs[v].mode, vecs[v].pat, vecs[v].early,
                vecs[v].csum, vecs[v].errs, -1);
    end

    cur_tag = "size0";
    @(negedge i_clk);
    i_packet_size_in_bytes = 12'd0;
    i_tanswer_ready = 1'b1;
    i_tx_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      #1;
      chk("valid", o_tx_valid, 0);
      chk("pop", o_tmanager_ready, 0);
      chk("busy", o_busy, 0);
    end
    i_tanswer_ready = 1'b0;

    cur_tag = "abort";
    run_frame(4, 0, 0, -1, 'h0E, 0, 4);
    cur_tag = "after_abort";
    run_frame(4, 0, 0, -1, 'h0E, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/task_7_answer_framer.md
TASK_7_ANSWER_FRAMER -- requirements
Module: task_7_answer_framer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default TASK_7_SYNC_BYTE (8'hA5), the frame start marker.
REQ-002 SHALL have port i_clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_tanswer_ready  in  1  task output has a packet available.
REQ-005 SHALL have port i_tdata  in  8  current payload byte from task output FIFO.
REQ-006 SHALL have port i_tanswer_data_last  in  1  task output marks final payload byte.
REQ-007 SHALL have port i_packet_size_in_bytes  in  12  payload length announced by task output.
REQ-008 SHALL have port o_tmanager_ready  out  1  one-cycle pop strobe to task output FIFO.
REQ-009 SHALL have port o_tx_data  out  8  framed byte stream.
REQ-010 SHALL have port o_tx_valid  out  1  o_tx_data valid.
REQ-011 SHALL have port i_tx_ready  in  1  sink accepts byte when high with o_tx_valid.
REQ-012 SHALL have port o_tx_last  out  1  marks checksum byte (final byte of frame).
REQ-013 SHALL have port o_busy  out  1  high from frame start until checksum accepted.
REQ-014 SHALL have port o_err_len  out  1  one-cycle pulse on length mismatch.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, {4'h0,len[11:8]}, len[7:0], len payload bytes, checksum.
REQ-016 Checksum SHALL be the mod-256 sum of the two length bytes and all payload bytes (sync excluded).
REQ-017 States SHALL be IDLE, SYNC, LEN_HI, LEN_LO, FETCH, SETTLE, PAYLOAD, CSUM.
REQ-018 IDLE -> SYNC when i_tanswer_ready=1 and i_packet_size_in_bytes!=0; length latched at that edge; size 0 keeps IDLE.
REQ-019 SYNC/LEN_HI/LEN_LO/PAYLOAD/CSUM SHALL each present one byte with o_tx_valid=1 and advance only on the edge where o_tx_valid&&i_tx_ready.
REQ-020 o_tx_data, o_tx_last SHALL be registered and stable while o_tx_valid=1 and i_tx_ready=0.
REQ-021 LEN_LO accepted -> FETCH; FETCH with i_tanswer_ready=1 SHALL assert o_tmanager_ready for exactly that cycle and capture i_tdata into the holding register at the same edge; FETCH with i_tanswer_ready=0 waits.
REQ-022 FETCH -> SETTLE -> PAYLOAD; SETTLE (1 cycle, o_tmanager_ready=0) allows FIFO output to update.
REQ-023 PAYLOAD accepted: payload counter+1; if counter reaches latched length -> CSUM, else -> FETCH.
REQ-024 o_tmanager_ready SHALL never be high two consecutive cycles and never outside FETCH.
REQ-025 Payload counter 12 bits; latched length is authoritative; i_tanswer_data_last only checked.
REQ-026 o_err_len SHALL pulse when captured byte has i_tanswer_data_last=1 but is not byte len, or byte len captured with i_tanswer_data_last=0; framing continues unchanged.
REQ-027 CSUM presents checksum with o_tx_last=1; accepted -> IDLE, o_busy=0 next cycle.
REQ-028 Steady-state throughput with i_tx_ready=1: one payload byte per 3 cycles.

Reset
REQ-029 On i_rst: state IDLE, o_tx_valid=0, o_tx_last=0, o_tmanager_ready=0, o_busy=0, o_err_len=0, o_tx_data=0, counter/checksum/length cleared, effective next cycle.
REQ-030 Reset mid-frame SHALL abandon the frame; no partial continuation afterwards.

Structure
REQ-031 TASK_7_SYNC_BYTE and the framer state enum SHALL live in task_pkg alongside TASK_7_PKT_SIZE_IN_BYTES.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Size 4, bytes 01 02 03 04, i_tx_ready=1 -> A5 00 04 01 02 03 04 0E, o_tx_last only on 0E, four o_tmanager_ready pulses.
REQ-034 Same packet, i_tx_ready toggling 1/0 each cycle -> identical byte sequence, data stable while stalled.
REQ-035 Size 4095, bytes = index mod 256 -> header A5 0F FF, 4095 payload bytes, correct checksum, counter no wrap.
REQ-036 Size 4, i_tanswer_data_last on byte 2 -> o_err_len one pulse, frame still 8 bytes.
REQ-037 i_rst during payload byte 2 -> o_tx_valid=0 next cycle, o_busy=0, next packet framed from SYNC.
REQ-038 i_tanswer_ready=1 with size 0 -> stays IDLE, no o_tx_valid, no o_tmanager_ready.
